// File: rtl/if_id_fetch_queue_if.sv
// IF/ID fetch queue bus: fetch issue and SRAM return from IF, head entry and
// back-pressure towards ID/IF.
interface if_id_fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              fetch_req;
  logic [PC_W-1:0]   fetch_pc;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              flush;
  logic              id_ready;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic              stallreq_if;
  logic [CW-1:0]     count;
  logic              overflow_err;

  // Pipeline side driving the queue
  modport master (
    output fetch_req, fetch_pc, inst_sram_rdata, flush, id_ready,
    input  id_valid, id_pc, id_inst, stallreq_if, count, overflow_err
  );

  // The queue itself
  modport slave (
    input  fetch_req, fetch_pc, inst_sram_rdata, flush, id_ready,
    output id_valid, id_pc, id_inst, stallreq_if, count, overflow_err
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling queue: pairs each fetch PC with the SRAM data returned one
// cycle later, buffers DEPTH entries first-word-fall-through, back-pressures
// IF, and discards everything on a branch flush.
module if_id_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input logic                clk,
  input logic                rst,
  if_id_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic              pend_v;
  logic [PC_W-1:0]   pend_pc;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_r;
  logic              ovf_r;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic stall;

  // Handshake decode; a full queue only takes a push when the head leaves too
  always_comb begin
    full  = (count_r == CW'(DEPTH));
    pop   = (count_r != '0) && bus.id_ready && !bus.flush;
    push  = pend_v && !bus.flush && (!full || pop);
    stall = ({1'b0, count_r} + (CW + 1)'(pend_v)) >= (CW + 1)'(DEPTH);
  end

  // Pending stage: remembers the PC of the read whose data arrives next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else begin
      pend_v <= bus.fetch_req && !bus.flush;
      if (bus.fetch_req && !bus.flush)
        pend_pc <= bus.fetch_pc;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; cleared only by reset, flush just rewinds the pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]   <= pend_pc;
      inst_mem[wr_ptr] <= bus.inst_sram_rdata;
    end
  end

  // Sticky error: IF issued a fetch it was told to hold back
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_r <= 1'b0;
    else if (bus.fetch_req && stall && !bus.flush)
      ovf_r <= 1'b1;
  end

  assign bus.id_valid     = (count_r != '0);
  assign bus.id_pc        = pc_mem[rd_ptr];
  assign bus.id_inst      = inst_mem[rd_ptr];
  assign bus.stallreq_if  = stall;
  assign bus.count        = count_r;
  assign bus.overflow_err = ovf_r;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for the IF/ID fetch queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_if_id_fetch_queue;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  if_id_fetch_queue_if #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) bus ();

  if_id_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic        m_pend_v;
  logic [31:0] m_pend_pc;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic m_stall();
    return (mq_pc.size() + int'(m_pend_v)) >= DEPTH;
  endfunction

  task automatic model_reset();
    mq_pc.delete();
    mq_inst.delete();
    m_pend_v  = 1'b0;
    m_pend_pc = '0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_edge(input logic fr, input logic [31:0] pc, input logic [31:0] rd,
                            input logic fl, input logic rdy);
    if (fl) begin
      mq_pc.delete();
      mq_inst.delete();
      m_pend_v = 1'b0;
    end else begin
      if (fr && m_stall()) m_ovf = 1'b1;
      if (mq_pc.size() != 0 && rdy) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (m_pend_v && mq_pc.size() < DEPTH) begin
        mq_pc.push_back(m_pend_pc);
        mq_inst.push_back(rd);
      end
      m_pend_v = fr;
      if (fr) m_pend_pc = pc;
    end
  endtask

  task automatic check_outputs();
    chk("id_valid", 64'(bus.id_valid), 64'(mq_pc.size() != 0));
    chk("count", 64'(bus.count), 64'(mq_pc.size()));
    chk("stallreq_if", 64'(bus.stallreq_if), 64'(m_stall()));
    chk("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
    if (mq_pc.size() != 0) begin
      chk("id_pc", 64'(bus.id_pc), 64'(mq_pc[0]));
      chk("id_inst", 64'(bus.id_inst), 64'(mq_inst[0]));
    end
  endtask

  // One cycle: check at the falling edge, drive, then advance model at the rising edge
  task automatic step(input logic fr, input logic [31:0] pc, input logic [31:0] rd,
                      input logic fl, input logic rdy);
    @(negedge clk);
    check_outputs();
    bus.fetch_req       = fr;
    bus.fetch_pc        = pc;
    bus.inst_sram_rdata = rd;
    bus.flush           = fl;
    bus.id_ready        = rdy;
    @(posedge clk);
    model_edge(fr, pc, rd, fl, rdy);
  endtask

  initial begin
    logic        fr;
    logic        fl;
    logic [31:0] pc;
    logic [31:0] next_pc;

    rst = 1'b1;
    bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.inst_sram_rdata = '0;
    bus.flush = 1'b0; bus.id_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_pc", 64'(bus.id_pc), 64'd0);
    chk("rst_inst", 64'(bus.id_inst), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_stall", 64'(bus.stallreq_if), 64'd0);
    chk("rst_ovf", 64'(bus.overflow_err), 64'd0);
    rst = 1'b0;

    // Streaming with ID always ready: two-cycle latency, in order
    step(1'b1, 32'hbfc00000, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'hbfc00004, 32'h11111111, 1'b0, 1'b1);
    #1;
    chk("lat_valid", 64'(bus.id_valid), 64'd1);
    chk("lat_pc", 64'(bus.id_pc), 64'hbfc00000);
    step(1'b1, 32'hbfc00008, 32'h22222222, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h33333333, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    // ID stalled, IF honours back-pressure until the queue fills
    pc = 32'hbfc00000;
    for (int i = 0; i < 7; i++) begin
      fr = !m_stall();
      step(fr, pc, {4{i[7:0] + 8'h10}}, 1'b0, 1'b0);
      if (fr) pc += 4;
    end
    #1;
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_head", 64'(bus.id_pc), 64'(mq_pc[0]));

    // Forced fetch while full: overflow flagged, then push+pop at full
    step(1'b1, 32'hbfc0f000, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'hcafef00d, 1'b0, 1'b1);
    #1;
    chk("ovf_set", 64'(bus.overflow_err), 64'd1);
    chk("pp_count", 64'(bus.count), 64'd4);
    // Forced fetch with no pop: response dropped, entries untouched
    step(1'b1, 32'hbfc0f004, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'hbadbadba, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with three queued entries and one in flight
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    pc = 32'hbfc00040;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pc, {4{i[7:0] + 8'h40}}, 1'b0, 1'b0);
      pc += 4;
    end
    step(1'b0, 32'h0, 32'hdeadbeef, 1'b1, 1'b0);
    #1;
    chk("fl_count", 64'(bus.count), 64'd0);
    chk("fl_valid", 64'(bus.id_valid), 64'd0);
    chk("fl_stall", 64'(bus.stallreq_if), 64'd0);
    step(1'b1, 32'hbfc00100, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'hbfc00104, 32'haaaa0100, 1'b0, 1'b0);
    #1;
    chk("pf_pc", 64'(bus.id_pc), 64'hbfc00100);
    chk("pf_inst", 64'(bus.id_inst), 64'haaaa0100);
    step(1'b0, 32'h0, 32'haaaa0104, 1'b0, 1'b0);
    #1;
    chk("pre_rst_count", 64'(bus.count), 64'd2);

    // Asynchronous reset mid-cycle
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.id_valid), 64'd0);
    chk("arst_pc", 64'(bus.id_pc), 64'd0);
    chk("arst_inst", 64'(bus.id_inst), 64'd0);
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_ovf", 64'(bus.overflow_err), 64'd0);
    model_reset();
    bus.fetch_req = 1'b0;
    #1 rst = 1'b0;

    // Random traffic
    next_pc = 32'hbfc00000;
    for (int i = 0; i < 600; i++) begin
      fl = ($urandom_range(0, 19) == 0);
      if (m_stall()) fr = ($urandom_range(0, 15) == 0);
      else           fr = ($urandom_range(0, 3) != 0);
      step(fr, next_pc, $urandom, fl, 1'($urandom_range(0, 1)));
      if (fl) next_pc = {$urandom_range(0, 255), 8'h00} | 32'hbfc00000;
      else if (fr) next_pc += 4;
    end
    step(1'b0, 32'h0, $urandom, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
